// File: rtl/fpu_pkg.sv
// Shared types for the FPU issue controller.
//   unit_class_t : execution unit an instruction is steered to
//   ds_state_t   : div/sqrt sequencing state
//   res_entry_t  : one writeback-reservation slot {v, rd, wflags}
//   classify()   : priority decode of the control signals into a unit class
package fpu_pkg;

    localparam int DEF_FMA_LAT  = 3;
    localparam int DEF_FAST_LAT = 2;
    localparam int DEF_NREG     = 32;

    typedef enum logic [1:0] {
        UC_DS,
        UC_FMA,
        UC_FAST,
        UC_TOINT
    } unit_class_t;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_REQ,
        DS_WAIT
    } ds_state_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wflags;
    } res_entry_t;

    // div/sqrt outranks fma, which outranks the fast pipe; anything that
    // matches none of the explicit classes still goes down the fast pipe
    function automatic unit_class_t classify(input logic div,
                                             input logic sqrt,
                                             input logic fma,
                                             input logic fastpipe,
                                             input logic fromint,
                                             input logic toint);
        unit_class_t uc;
        if (div || sqrt)
            uc = UC_DS;
        else if (fma)
            uc = UC_FMA;
        else if (fastpipe || fromint)
            uc = UC_FAST;
        else if (toint)
            uc = UC_TOINT;
        else
            uc = UC_FAST;
        return uc;
    endfunction

endpackage

// File: rtl/fpu_wb_reserve.sv
// Writeback-port reservation shift register.
//   clock, reset : clock and asynchronous active-high reset
//   query_lat    : latency whose completion slot is being asked about
//   slot_free    : that slot is empty once this cycle's shift happens
//   ins_valid    : write ins_entry into slot ins_lat (post-shift position)
//   ins_lat      : slot index 1..LAT for the insert
//   ins_entry    : {v, rd, wflags} to store
//   head         : slot 1, the entry completing this cycle
module fpu_wb_reserve
    import fpu_pkg::*;
#(
    parameter int LAT = DEF_FMA_LAT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] query_lat,
    output logic       slot_free,
    input  logic       ins_valid,
    input  logic [2:0] ins_lat,
    input  res_entry_t ins_entry,
    output res_entry_t head
);

    res_entry_t res [1:LAT];

    // Entries march toward slot 1 every cycle; the insert lands in the
    // post-shift position so it completes exactly ins_lat cycles later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= LAT; i++)
                res[i] <= '0;
        end else begin
            for (int i = 1; i < LAT; i++)
                res[i] <= res[i+1];
            res[LAT] <= '0;
            for (int i = 1; i <= LAT; i++)
                if (ins_valid && ins_lat == 3'(i))
                    res[i] <= ins_entry;
        end
    end

    // After the shift, slot i holds what is now in slot i+1; the top slot
    // is always refilled empty.
    always_comb begin
        slot_free = 1'b1;
        for (int i = 1; i < LAT; i++)
            if (query_lat == 3'(i))
                slot_free = !res[i+1].v;
    end

    assign head = res[1];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: steers decoded instructions to the FMA pipe, the
// fast pipe, the to-int path or the iterative div/sqrt unit, tracks pending
// FP register writes and arbitrates the single FP writeback port.
//   clock, reset          : clock, asynchronous active-high reset
//   io_req_*              : decoded instruction and its register specifiers
//   io_sigs_*             : decoded control signals
//   io_fma/fast/toint_valid : one-cycle issue pulses
//   io_ds_req_*/resp_*    : div/sqrt unit valid/ready handshakes
//   io_wb_*               : registered FP regfile write port
//   io_busy               : something still in flight
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int FMA_LAT  = DEF_FMA_LAT,
    parameter int FAST_LAT = DEF_FAST_LAT,
    parameter int NREG     = DEF_NREG
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_req_valid,
    output logic       io_req_ready,
    input  logic [4:0] io_req_rd,
    input  logic [4:0] io_req_rs1,
    input  logic [4:0] io_req_rs2,
    input  logic [4:0] io_req_rs3,
    input  logic       io_sigs_wen,
    input  logic       io_sigs_ren1,
    input  logic       io_sigs_ren2,
    input  logic       io_sigs_ren3,
    input  logic       io_sigs_fma,
    input  logic       io_sigs_div,
    input  logic       io_sigs_sqrt,
    input  logic       io_sigs_fastpipe,
    input  logic       io_sigs_fromint,
    input  logic       io_sigs_toint,
    input  logic       io_sigs_wflags,
    output logic       io_fma_valid,
    output logic       io_fast_valid,
    output logic       io_toint_valid,
    output logic       io_ds_req_valid,
    input  logic       io_ds_req_ready,
    output logic       io_ds_req_sqrt,
    input  logic       io_ds_resp_valid,
    output logic       io_ds_resp_ready,
    output logic       io_wb_valid,
    output logic [4:0] io_wb_rd,
    output logic       io_wb_wflags,
    output logic       io_busy
);

    unit_class_t     req_class;
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;
    logic            raw;
    logic            waw;
    logic            class_ok;
    logic            accept;
    logic            ds_accept;
    logic            ds_take;
    logic [2:0]      lat;
    logic            slot_free;
    logic            ins_valid;
    res_entry_t      ins_entry;
    res_entry_t      head;
    ds_state_t       ds_state;
    ds_state_t       ds_next;
    logic [4:0]      ds_rd;
    logic            ds_wflags;
    logic            ds_sqrt_q;
    logic            wb_valid_q;
    logic [4:0]      wb_rd_q;
    logic            wb_wflags_q;

    assign req_class = classify(io_sigs_div, io_sigs_sqrt, io_sigs_fma,
                                io_sigs_fastpipe, io_sigs_fromint, io_sigs_toint);

    // Hazards look only at the registered scoreboard, so a writeback
    // clearing a register this cycle does not release a waiting reader.
    assign raw = (io_sigs_ren1 & sb[io_req_rs1]) |
                 (io_sigs_ren2 & sb[io_req_rs2]) |
                 (io_sigs_ren3 & sb[io_req_rs3]);
    assign waw = io_sigs_wen & sb[io_req_rd];

    assign lat = (req_class == UC_FMA) ? 3'(FMA_LAT) : 3'(FAST_LAT);

    always_comb begin
        class_ok = 1'b0;
        case (req_class)
            UC_DS:    class_ok = (ds_state == DS_IDLE);
            UC_FMA:   class_ok = slot_free;
            UC_FAST:  class_ok = slot_free;
            UC_TOINT: class_ok = 1'b1;
            default:  class_ok = 1'b0;
        endcase
    end

    // Held low during reset so nothing is accepted while state is clearing.
    assign io_req_ready   = !reset && !raw && !waw && class_ok;
    assign accept         = io_req_valid && io_req_ready;
    assign io_fma_valid   = accept && (req_class == UC_FMA);
    assign io_fast_valid  = accept && (req_class == UC_FAST);
    assign io_toint_valid = accept && (req_class == UC_TOINT);
    assign ds_accept      = accept && (req_class == UC_DS);

    assign ins_valid = io_fma_valid || io_fast_valid;
    assign ins_entry = '{v: 1'b1, rd: io_req_rd, wflags: io_sigs_wflags};

    fpu_wb_reserve #(
        .LAT(FMA_LAT)
    ) u_reserve (
        .clock     (clock),
        .reset     (reset),
        .query_lat (lat),
        .slot_free (slot_free),
        .ins_valid (ins_valid),
        .ins_lat   (lat),
        .ins_entry (ins_entry),
        .head      (head)
    );

    // Fixed-latency completions own the port; a div/sqrt result waits.
    assign ds_take          = (ds_state == DS_WAIT) && io_ds_resp_valid && !head.v;
    assign io_ds_resp_ready = ds_take;
    assign io_ds_req_valid  = (ds_state == DS_REQ);
    assign io_ds_req_sqrt   = ds_sqrt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ds_state <= DS_IDLE;
        else
            ds_state <= ds_next;
    end

    always_comb begin
        ds_next = ds_state;
        case (ds_state)
            DS_IDLE: if (ds_accept)       ds_next = DS_REQ;
            DS_REQ:  if (io_ds_req_ready) ds_next = DS_WAIT;
            DS_WAIT: if (ds_take)         ds_next = DS_IDLE;
            default:                      ds_next = DS_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ds_rd     <= '0;
            ds_wflags <= 1'b0;
            ds_sqrt_q <= 1'b0;
        end else if (ds_accept) begin
            ds_rd     <= io_req_rd;
            ds_wflags <= io_sigs_wflags;
            ds_sqrt_q <= io_sigs_sqrt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_wflags_q <= 1'b0;
        end else begin
            wb_valid_q  <= head.v || ds_take;
            wb_rd_q     <= head.v ? head.rd     : ds_rd;
            wb_wflags_q <= head.v ? head.wflags : ds_wflags;
        end
    end

    assign io_wb_valid  = wb_valid_q;
    assign io_wb_rd     = wb_rd_q;
    assign io_wb_wflags = wb_wflags_q;

    // WAW blocks a set on a register being written back, so the clear and
    // the set never target the same bit in one cycle.
    always_comb begin
        sb_next = sb;
        if (wb_valid_q)
            sb_next[wb_rd_q] = 1'b0;
        if (accept && io_sigs_wen && req_class != UC_TOINT)
            sb_next[io_req_rd] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sb <= '0;
        else
            sb <= sb_next;
    end

    assign io_busy = (|sb) || (ds_state != DS_IDLE);

endmodule
